// File: rtl/sha512_msg_packer.sv
// SHA-512 front end: packs 64-bit big-endian message words into 1024-bit blocks
// and tracks the running message length in bits for the final-block path.
//
// state | meaning
// FILL  | accepting words into the block buffer
// OUT   | block presented downstream, input stalled until blk_ready
module sha512_msg_packer (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic [3:0]    in_keep,
  input  logic          in_last,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic [1023:0] blk_data,
  output logic          blk_last,
  output logic [127:0]  blk_len,
  output logic          proto_err
);

  typedef enum logic {FILL, OUT} state_t;

  state_t          state;
  logic [1023:0]   buffer;
  logic [3:0]      idx;
  logic [127:0]    len;
  logic            last;

  logic            bad_beat;
  logic [3:0]      keep_eff;
  logic [63:0]     word_masked;
  logic [9:0]      wr_base;
  logic            beat_fire;

  // Illegal keep values still consume a full word so the stream stays aligned.
  always_comb begin
    bad_beat = (in_keep > 4'd8) ||
               ((in_keep != 4'd8) && !in_last) ||
               ((in_keep == 4'd0) && ((idx != 4'd0) || (len != 128'd0)));
    keep_eff = bad_beat ? 4'd8 : in_keep;
    word_masked = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < keep_eff)
        word_masked[63-8*b -: 8] = in_data[63-8*b -: 8];
    end
  end

  assign wr_base   = {~idx, 6'd0};
  assign beat_fire = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      in_ready  <= 1'b0;
      blk_valid <= 1'b0;
      buffer    <= '0;
      idx       <= '0;
      len       <= '0;
      last      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (beat_fire) begin
            buffer[wr_base +: 64] <= word_masked;
            len <= len + {121'd0, keep_eff, 3'd0};
            idx <= idx + 4'd1;
            if (bad_beat)
              proto_err <= 1'b1;
            if ((idx == 4'd15) || in_last) begin
              state     <= OUT;
              last      <= in_last;
              in_ready  <= 1'b0;
              blk_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (blk_ready) begin
            buffer    <= '0;
            idx       <= '0;
            state     <= FILL;
            blk_valid <= 1'b0;
            in_ready  <= 1'b1;
            if (last) begin
              len  <= '0;
              last <= 1'b0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign blk_data = buffer;
  assign blk_last = last;
  assign blk_len  = len;

endmodule

// File: tb/tb_sha512_msg_packer.sv
// Self-checking bench for sha512_msg_packer: table vectors, directed corner
// sequences and random legal messages checked against a word-list block model.
module tb_sha512_msg_packer;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic [3:0]    in_keep = '0;
  logic          in_last = 1'b0;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [1023:0] blk_data;
  logic          blk_last;
  logic [127:0]  blk_len;
  logic          proto_err;

  sha512_msg_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .blk_len(blk_len), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1023:0] data;
    logic          last;
    logic [127:0]  len;
  } blk_t;

  typedef struct {
    string        name;
    logic [63:0]  d;
    logic [3:0]   k;
    logic [63:0]  exp_w15;
    logic [127:0] exp_len;
  } vec_t;

  blk_t        exp_q[$];
  logic [63:0] msg_d[$];
  logic [3:0]  msg_k[$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_data(string name, logic [1023:0] act, logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int w = 15; w >= 0; w--) begin
        if (act[w*64 +: 64] !== exp[w*64 +: 64]) begin
          $display("FAIL %s word%0d actual=%h expected=%h", name, w,
                   act[w*64 +: 64], exp[w*64 +: 64]);
          break;
        end
      end
    end
  endtask

  // Invariant outside reset: exactly one side of the packer is ready.
  logic armed;
  always @(posedge clk or posedge rst)
    if (rst) armed <= 1'b0; else armed <= 1'b1;
  always @(negedge clk)
    if (armed && !rst) chk("ready_xor_valid", {in_ready, blk_valid}, in_ready ? 2'b10 : 2'b01);

  function automatic logic [63:0] mask_word(logic [63:0] d, int k);
    if (k >= 8) return d;
    if (k == 0) return 64'd0;
    return d & ~((64'd1 << (64 - 8*k)) - 64'd1);
  endfunction

  // Reference: the message is a list of words; every 16 words (or the end) is one block.
  task automatic build_expect();
    blk_t b;
    int pos = 0;
    logic [127:0] total = '0;
    b.data = '0;
    for (int i = 0; i < msg_d.size(); i++) begin
      total += 128'(8 * msg_k[i]);
      b.data[1023 - 64*pos -: 64] = mask_word(msg_d[i], int'(msg_k[i]));
      pos++;
      if (pos == 16 || i == msg_d.size() - 1) begin
        b.last = (i == msg_d.size() - 1);
        b.len  = total;
        exp_q.push_back(b);
        b.data = '0;
        pos = 0;
      end
    end
  endtask

  task automatic send_beat(logic [63:0] d, logic [3:0] k, logic l, int gap);
    int n = 0;
    repeat (gap) begin
      in_data = 64'($urandom) << 32 | 64'($urandom);
      @(posedge clk); #1;
    end
    in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume(string name, blk_t exp, int hold);
    logic [1023:0] snap_d;
    logic [127:0]  snap_l;
    logic          snap_last;
    chk({name, "_blk_valid"}, blk_valid, 1'b1);
    chk_data({name, "_data"}, blk_data, exp.data);
    chk({name, "_last"}, blk_last, exp.last);
    chk({name, "_len"}, blk_len, exp.len);
    snap_d = blk_data; snap_l = blk_len; snap_last = blk_last;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, {blk_valid, in_ready}, 2'b10);
      chk_data({name, "_hold_data"}, blk_data, snap_d);
      chk({name, "_hold_meta"}, {blk_last, blk_len}, {snap_last, snap_l});
    end
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    chk({name, "_release"}, {blk_valid, in_ready}, 2'b01);
  endtask

  task automatic run_msg(string name, int hold, bit gaps);
    int n;
    build_expect();
    n = msg_d.size();
    for (int i = 0; i < n; i++) begin
      send_beat(msg_d[i], msg_k[i], i == n - 1, gaps ? $urandom_range(0, 1) : 0);
      if (i % 16 == 15 || i == n - 1) begin
        if (exp_q.size() == 0) chk({name, "_model_empty"}, 1'b0, 1'b1);
        else consume(name, exp_q.pop_front(), hold);
      end else begin
        chk({name, "_no_blk_mid"}, blk_valid, 1'b0);
      end
    end
    msg_d.delete(); msg_k.delete();
  endtask

  task automatic check_reset_outputs(string name);
    chk({name, "_ctl"}, {in_ready, blk_valid, blk_last, proto_err}, 4'b0000);
    chk({name, "_len"}, blk_len, 128'd0);
    chk_data({name, "_data"}, blk_data, '0);
  endtask

  vec_t vecs[5];
  blk_t eb;

  initial begin
    vecs[0] = '{"abc",   64'h616263FF_FFFFFFFF, 4'd3, 64'h61626300_00000000, 128'd24};
    vecs[1] = '{"empty", 64'hFFFFFFFF_FFFFFFFF, 4'd0, 64'h0,                 128'd0};
    vecs[2] = '{"full8", 64'h01234567_89ABCDEF, 4'd8, 64'h01234567_89ABCDEF, 128'd64};
    vecs[3] = '{"keep1", 64'hA5FFFFFF_FFFFFFFF, 4'd1, 64'hA5000000_00000000, 128'd8};
    vecs[4] = '{"keep7", 64'h11223344_55667788, 4'd7, 64'h11223344_55667700, 128'd56};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    chk("in_ready_before_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", in_ready, 1'b1);

    for (int v = 0; v < 5; v++) begin
      send_beat(vecs[v].d, vecs[v].k, 1'b1, 0);
      eb.data = {vecs[v].exp_w15, 960'd0};
      eb.last = 1'b1;
      eb.len  = vecs[v].exp_len;
      consume(vecs[v].name, eb, 0);
    end
    chk("no_proto_err_legal", proto_err, 1'b0);

    for (int i = 0; i < 17; i++) begin
      msg_d.push_back({$urandom, $urandom}); msg_k.push_back(4'd8);
    end
    run_msg("w17", 0, 0);
    for (int i = 0; i < 16; i++) begin
      msg_d.push_back({$urandom, $urandom}); msg_k.push_back(4'd8);
    end
    run_msg("w16", 0, 0);
    // Backpressure: block held 5 cycles, then the next message lands in word 15.
    for (int i = 0; i < 3; i++) begin
      msg_d.push_back({$urandom, $urandom}); msg_k.push_back(i == 2 ? 4'd5 : 4'd8);
    end
    run_msg("bp", 5, 0);
    send_beat(64'hCAFEBABE_12345678, 4'd8, 1'b1, 0);
    eb.data = {64'hCAFEBABE_12345678, 960'd0}; eb.last = 1'b1; eb.len = 128'd64;
    consume("after_bp", eb, 0);

    // Protocol error: short keep without last is taken as a full word.
    send_beat(64'hDEADBEEF_CAFEF00D, 4'd4, 1'b0, 0);
    chk("proto_err_set", proto_err, 1'b1);
    send_beat(64'h0F0E0D0C_0B0A0908, 4'd8, 1'b1, 0);
    eb.data = {64'hDEADBEEF_CAFEF00D, 64'h0F0E0D0C_0B0A0908, 896'd0};
    eb.last = 1'b1; eb.len = 128'd128;
    consume("proto", eb, 0);
    chk("proto_err_sticky", proto_err, 1'b1);

    for (int i = 0; i < 7; i++) send_beat({$urandom, $urandom}, 4'd8, 1'b0, 0);
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    #1 rst = 1'b0;
    chk("rst_mid_ready_pre_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_mid_ready_post_edge", in_ready, 1'b1);
    send_beat(64'h55AA55AA_00FF00FF, 4'd8, 1'b1, 0);
    eb.data = {64'h55AA55AA_00FF00FF, 960'd0}; eb.last = 1'b1; eb.len = 128'd64;
    consume("post_rst", eb, 0);

    send_beat(64'h1, 4'd8, 1'b1, 0);
    chk("out_before_rst", blk_valid, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_out");
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int m = 0; m < 20; m++) begin
      int nw = $urandom_range(1, 40);
      for (int i = 0; i < nw; i++) begin
        msg_d.push_back({$urandom, $urandom});
        msg_k.push_back(i == nw - 1 ? 4'($urandom_range(1, 8)) : 4'd8);
      end
      run_msg("rand", $urandom_range(0, 3), 1);
    end
    chk("rand_no_proto_err", proto_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/sha512_msg_packer.md
# sha512_msg_packer

Streaming front end for the SHA-512 datapath. Accepts a message as a sequence of 64-bit big-endian words over a valid/ready handshake and assembles them into 1024-bit blocks. Tracks the running message length in bits and hands each block to the downstream block-processing stage:

- intermediate blocks go to the full-block path;
- the final block goes to the last-block path, together with the 128-bit bit length.

Padding is performed downstream. This block only zero-fills unused bytes.

## Interface

Parameters: none. Widths are fixed by SHA-512.

Ports:

- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer can accept a beat.
- in_data  in  64  message word, first byte in bits [63:56].
- in_keep  in  4  number of valid leading bytes, 0..8. Values below 8 are legal only on a last beat. 0 is legal only on the first beat of an empty message.
- in_last  in  1  final beat of the message.
- blk_valid  out  1  block available.
- blk_ready  in  1  consumer accepts block.
- blk_data  out  1024  block. Word 15 = bits [1023:960] holds the first word of the block.
- blk_last  out  1  block is the final block of the message.
- blk_len  out  128  total message bits accepted so far, including this block. Downstream uses it as `l` on the final block.
- proto_err  out  1  sticky protocol-violation flag.

## Operation

- FSM states: FILL, OUT. Reset state is FILL.
- Registers:
  - buffer (1024 b)
  - word index idx (4 b)
  - length counter len (128 b)
  - last flag
  - proto_err
- FILL:
  - in_ready = 1, blk_valid = 0.
  - On handshake (in_valid & in_ready), write word `in_data` masked to its first `in_keep` bytes (the remaining bytes are forced to 0) into buffer word 15−idx.
  - len += 8·in_keep. Arithmetic is modulo 2^128.
  - idx += 1.
  - If idx was 15 or in_last = 1: go to OUT and set last = in_last.
- OUT:
  - in_ready = 0, blk_valid = 1.
  - blk_data, blk_last and blk_len are driven from registers and are stable while blk_valid = 1 and blk_ready = 0.
  - On blk_ready: clear the buffer to 0 and set idx = 0. If last = 1, clear len to 0 and clear the last flag. Return to FILL.
- Word positions not written in a final partial block read as 0.
- Empty message (in_keep = 0 with in_last on the first beat): emits one block with all bits 0, blk_last = 1, blk_len = 0.
- A message whose length is an exact multiple of 1024 bits emits its final full block with blk_last = 1. The extra padding block is produced downstream.
- Protocol errors: in_keep > 8, in_keep < 8 with in_last = 0, or in_keep = 0 when idx ≠ 0 or len ≠ 0.
  - The error sets proto_err, which stays set until reset.
  - The beat is still accepted, with in_keep clamped to 8.
- Reset (asynchronous, any time, including mid-block or in OUT) clears all registers immediately:
  - in_ready = 0 while rst is high; in_ready = 1 from the first clk edge after rst falls.
  - blk_valid = 0, blk_last = 0, blk_len = 0, blk_data = 0, proto_err = 0.
  - Any partial block is discarded.

## Timing

- Input beat to block: blk_valid rises on the clk edge that accepts the 16th word or the last beat, i.e. visible one cycle after the handshake.
- Sustained throughput: 16 words per 17 cycles; the OUT cycle is a bubble on the input.
- Input and output are never simultaneously ready: in_ready = ~blk_valid outside reset.
- blk_valid is held until blk_ready. There is no combinational path from blk_ready to in_ready within the same cycle; the FSM returns to FILL on the next edge.
- in_valid may drop between beats with no effect on state.

## Test plan

- **"abc":** one beat, in_data = 64'h6162_6300_0000_0000 (bytes beyond 3 set to FF in stimulus), in_keep = 3, in_last = 1.
  - Expect one block: word 15 = 64'h6162630000000000, words 14..0 = 0, blk_last = 1, blk_len = 24, 1 cycle after the beat.
- **Empty message:** in_keep = 0, in_last = 1.
  - Expect a block of all zeros, blk_last = 1, blk_len = 0, proto_err = 0.
- **17 full words, last on word 17:**
  - First block: blk_last = 0, blk_len = 1024.
  - Second block: word 15 = word 17, blk_last = 1, blk_len = 1088.
  - The next message starts with len = 0.
- **Exactly 16 full words, last on word 16:**
  - Exactly one block, blk_last = 1, blk_len = 1024.
- **Backpressure:** hold blk_ready = 0 for 5 cycles after blk_valid.
  - in_ready stays 0 and the outputs are stable.
  - blk_ready = 1 → FILL on the next edge; the next beat is accepted into word 15.
- **Reset mid-block and protocol error:**
  - After 7 words, pulse rst asynchronously between edges. All outputs drop immediately, and a new 1-word message gives blk_len = 64.
  - Separately, in_keep = 4 with in_last = 0 sets proto_err = 1. It persists until rst and the length adds 64.
